// File: rtl/snake_pkg.sv
// Types shared across the snake game blocks.
package snake_pkg;
  typedef enum logic [2:0] {
    NONE  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } direction;
endpackage

// File: rtl/link_scheduler_if.sv
// Byte-link port bundle between link_scheduler (master) and the uart block (slave).
// Handshake: a byte is pushed on each cycle wr_uart=1 and popped on each cycle
// rd_uart=1; r_data is valid whenever rx_empty=0, and writes are only issued while tx_full=0.
interface link_scheduler_if;
   logic       tx_full;
   logic       wr_uart;
   logic [7:0] w_data;
   logic       rx_empty;
   logic [7:0] r_data;
   logic       rd_uart;

   modport master (input tx_full, rx_empty, r_data, output wr_uart, w_data, rd_uart);
   modport slave  (output tx_full, rx_empty, r_data, input wr_uart, w_data, rd_uart);
endinterface

// File: rtl/link_scheduler.sv
// Shares the UART byte link between the two boards: prioritised TX of local
// messages plus keepalive, RX opcode decode, and a link_up watchdog.
module link_scheduler
   import snake_pkg::*;
#(
   parameter int TIMEOUT_CYCLES   = 6_500_000,
   parameter int KEEPALIVE_CYCLES = 3_250_000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_dir,
   input  direction                 dir_in,
   input  logic                     req_col,
   input  logic [5:0]               col_in,
   input  logic                     req_click,
   input  logic [5:0]               click_in,
   link_scheduler_if.master         uart,
   output direction                 dir_out,
   output logic                     dir_valid,
   output logic [5:0]               col_out,
   output logic                     col_valid,
   output logic [5:0]               click_out,
   output logic                     click_valid,
   output logic [7:0]               err_cnt,
   output logic                     link_up,
   output logic [1:0]               tx_state
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int KA_W = $clog2(KEEPALIVE_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
   localparam logic [KA_W-1:0] KA_MAX = KA_W'(KEEPALIVE_CYCLES);

   typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, HOLD = 2'd2} tx_state_e;

   tx_state_e       state;
   logic            pend_dir, pend_col, pend_click, pend_ka;
   direction        dir_pay;
   logic [5:0]      col_pay, click_pay;
   logic [KA_W-1:0] ka_cnt;
   logic [WD_W-1:0] wd_cnt;

   assign tx_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         uart.wr_uart <= 1'b0;
         uart.w_data  <= 8'h00;
         pend_dir     <= 1'b0;
         pend_col     <= 1'b0;
         pend_click   <= 1'b0;
         pend_ka      <= 1'b0;
         dir_pay      <= NONE;
         col_pay      <= 6'h00;
         click_pay    <= 6'h00;
         ka_cnt       <= '0;
      end else begin
         uart.wr_uart <= 1'b0;
         case (state)
            IDLE: begin
               if ((pend_col || pend_click || pend_dir || pend_ka) && !uart.tx_full) begin
                  state        <= WRITE;
                  uart.wr_uart <= 1'b1;
                  if (pend_col) begin
                     uart.w_data <= {2'b10, col_pay};
                     pend_col    <= 1'b0;
                  end else if (pend_click) begin
                     uart.w_data <= {2'b11, click_pay};
                     pend_click  <= 1'b0;
                  end else if (pend_dir) begin
                     uart.w_data <= {2'b01, 3'b000, dir_pay};
                     pend_dir    <= 1'b0;
                  end else begin
                     uart.w_data <= 8'h3F;
                     pend_ka     <= 1'b0;
                  end
               end
            end
            WRITE:   state <= HOLD;
            HOLD:    state <= IDLE;
            default: state <= IDLE;
         endcase

         // Placed after the issue logic so a fresh request or keepalive tick wins over the clear.
         if (uart.wr_uart) begin
            ka_cnt <= '0;
         end else if (ka_cnt == KA_MAX) begin
            ka_cnt  <= '0;
            pend_ka <= 1'b1;
         end else begin
            ka_cnt <= ka_cnt + 1'b1;
         end
         if (req_col) begin
            pend_col <= 1'b1;
            col_pay  <= col_in;
         end
         if (req_click) begin
            pend_click <= 1'b1;
            click_pay  <= click_in;
         end
         if (req_dir) begin
            pend_dir <= 1'b1;
            dir_pay  <= dir_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         uart.rd_uart <= 1'b0;
         dir_out      <= NONE;
         dir_valid    <= 1'b0;
         col_out      <= 6'h00;
         col_valid    <= 1'b0;
         click_out    <= 6'h00;
         click_valid  <= 1'b0;
         err_cnt      <= 8'h00;
         wd_cnt       <= WD_MAX;
         link_up      <= 1'b0;
      end else begin
         uart.rd_uart <= 1'b0;
         dir_valid    <= 1'b0;
         col_valid    <= 1'b0;
         click_valid  <= 1'b0;
         link_up      <= (wd_cnt < WD_MAX);
         // rd_uart=1 means the head byte is being popped this cycle, so it is not decoded twice.
         if (!uart.rx_empty && !uart.rd_uart) begin
            uart.rd_uart <= 1'b1;
            wd_cnt       <= '0;
            case (uart.r_data[7:6])
               2'b01: begin
                  dir_out   <= direction'(uart.r_data[2:0]);
                  dir_valid <= 1'b1;
               end
               2'b10: begin
                  col_out   <= uart.r_data[5:0];
                  col_valid <= 1'b1;
               end
               2'b11: begin
                  click_out   <= uart.r_data[5:0];
                  click_valid <= 1'b1;
               end
               default: begin
                  if (uart.r_data[5:0] != 6'h3F && err_cnt != 8'hFF)
                     err_cnt <= err_cnt + 8'd1;
               end
            endcase
         end else if (wd_cnt != WD_MAX) begin
            wd_cnt <= wd_cnt + 1'b1;
         end
      end
   end

endmodule

// File: doc/link_scheduler.md
Name: link_scheduler

Overview:
Sequences the shared UART byte link between the two snake boards. Arbitrates three local message sources onto the single UART TX FIFO: direction, collision and click, plus an internally generated keepalive. Decodes received bytes into per-opcode outputs. A watchdog derives a link_up status for the game FSM. It sits between the game logic and the uart block and drives that block's wr_uart/w_data and rd_uart ports.

Parameters:
TIMEOUT_CYCLES, 6_500_000, cycles with no received byte before link_up drops (100 ms at 65 MHz)
KEEPALIVE_CYCLES, 3_250_000, idle TX cycles before a keepalive byte is queued; must be < TIMEOUT_CYCLES

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
req_dir  input  1  pulse: queue direction message
dir_in  input  direction  local direction (snake_pkg enum), zero-extended to 6-bit payload
req_col  input  1  pulse: queue collision message
col_in  input  6  collision payload
req_click  input  1  pulse: queue click message
click_in  input  6  click payload
tx_full  input  1  from uart
wr_uart  output  1  to uart, one-cycle write strobe
w_data  output  8  to uart, {opcode[1:0], payload[5:0]}
rx_empty  input  1  from uart
r_data  input  8  from uart, first-word-fall-through (valid while !rx_empty)
rd_uart  output  1  to uart, one-cycle pop strobe
dir_out  output  direction  last received direction
dir_valid  output  1  pulse on direction received
col_out  output  6  last received collision payload
col_valid  output  1  pulse on collision received
click_out  output  6  last received click payload
click_valid  output  1  pulse on click received
err_cnt  output  8  count of received error bytes, saturating
link_up  output  1  peer alive

Behaviour:
- Opcodes: 00 error/keepalive, 01 direction, 10 collision, 11 click. Byte 8'h3F (00 + payload 3F) = keepalive, never counted as error.
- Reset values: wr_uart=0, w_data=0, rd_uart=0, dir_out=NONE, col_out=0, click_out=0, all valid pulses 0, err_cnt=0, link_up=0, all pending flags clear, TX FSM IDLE, watchdog counter=TIMEOUT_CYCLES, keepalive counter=0.
- Pending slots: one per source (dir, col, click, keepalive). A request sets pend and latches the payload. A request while already pending overwrites the payload (latest wins). A request in the same cycle its slot is issued leaves pend set with the new payload.
- Keepalive: the counter increments each cycle wr_uart=0 and clears on wr_uart=1. At KEEPALIVE_CYCLES it sets pend_ka and clears.
- Priority, fixed: col > click > dir > keepalive.
- TX FSM, IDLE -> WRITE -> HOLD -> IDLE:
  - IDLE: if any pend and tx_full=0, select the winner, register w_data, clear its pend, go to WRITE.
  - WRITE: wr_uart=1 for exactly this cycle.
  - HOLD: one cycle with wr_uart=0 so tx_full reflects the write.
  - Max issue rate is 1 byte per 3 cycles. tx_full=1 holds the FSM in IDLE with pend retained.
- RX: when rx_empty=0 and rd_uart=0, decode r_data and assert rd_uart next cycle (one cycle), giving max 1 byte per 2 cycles. Outputs update and valid pulses fire in the same cycle rd_uart=1.
  - 01: dir_out=direction'(r_data[5:0]).
  - 10: col_out=r_data[5:0].
  - 11: click_out=r_data[5:0].
  - 00 with payload != 3F: err_cnt+1, saturating at 255.
- Watchdog: the counter is cleared to 0 on any decoded byte (keepalive included). Otherwise it increments, saturating at TIMEOUT_CYCLES. link_up = (counter < TIMEOUT_CYCLES), registered.
- TX and RX paths are independent and may be active in the same cycle.
- rst asserted mid-transfer: the FSM returns to IDLE and pending messages are dropped. A byte already written to the uart FIFO is not recalled.

Test Plan:
- Reset then idle 10 cycles -> wr_uart=0, rd_uart=0, link_up=0, err_cnt=0, dir_out=NONE.
- Pulse req_dir, req_col=6'h05 and req_click=6'h11 in the same cycle, tx_full=0 -> w_data sequence 8'h85, 8'hD1, then {2'b01, dir}, each wr_uart pulse 1 cycle wide and 3 cycles apart.
- Hold tx_full=1, pulse req_col twice with payloads 6'h01 then 6'h02, release tx_full -> exactly one write, w_data=8'h82.
- Feed r_data=8'h8A, rx_empty=0 for 1 byte -> rd_uart single pulse, col_valid pulse, col_out=6'h0A, link_up=1 next cycle. Then no bytes for TIMEOUT_CYCLES -> link_up=0.
- Feed 8'h00 three times and 8'h3F once -> err_cnt=3, no valid pulses. Feed 300 error bytes -> err_cnt=255.
- No requests for KEEPALIVE_CYCLES (small values, e.g. 20/50) -> wr_uart with w_data=8'h3F. Assert rst during HOLD -> wr_uart=0 next cycle, FSM IDLE, pend cleared.
